// File: rtl/mkio_word_receiver_if.sv
// Line-side and word-side signals of the MKIO word receiver.
// The slave modport is the receiver; the master modport is the transceiver/consumer side.
interface mkio_word_receiver_if;
  logic        rx_p;
  logic        rx_n;
  logic        rx_done;
  logic [15:0] rx_data;
  logic        rx_cd;
  logic        p_error;
  logic        rx_busy;

  modport master (
    output rx_p, rx_n,
    input  rx_done, rx_data, rx_cd, p_error, rx_busy
  );

  modport slave (
    input  rx_p, rx_n,
    output rx_done, rx_data, rx_cd, p_error, rx_busy
  );
endinterface

// File: rtl/mkio_word_receiver.sv
// MIL-STD-1553 Manchester-II word receiver: sync detection, 16 data bits MSB first,
// odd parity, one rx_done pulse per frame with sync type and error flag.
module mkio_word_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_MIN     = 20
) (
  input  logic                clk,
  input  logic                reset,
  mkio_word_receiver_if.slave bus
);
  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam logic [1:0]    LVL_HI    = 2'b10;
  localparam logic [1:0]    LVL_LO    = 2'b01;
  localparam logic [7:0]    SYNC_MIN_C = 8'(SYNC_MIN);
  localparam logic [7:0]    SYNC_LAST = 8'((3 * CLKS_PER_BIT) / 2 - 1);
  localparam logic [PW-1:0] PH_A      = PW'(CLKS_PER_BIT / 4);
  localparam logic [PW-1:0] PH_B      = PW'((3 * CLKS_PER_BIT) / 4);
  localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SYNC2 = 2'd1, DATA = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync1_q, sync2_q, prev_q;
  logic [7:0]    run_q, run_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [4:0]    bit_q, bit_d;
  logic [1:0]    samp_a_q, samp_a_d;
  logic [15:0]   shreg_q, shreg_d;
  logic          man_err_q, man_err_d;
  logic          cd_next_q, cd_next_d;
  logic          rx_done_q, rx_done_d;
  logic [15:0]   rx_data_q, rx_data_d;
  logic          rx_cd_q, rx_cd_d;
  logic          p_error_q, p_error_d;
  logic          rx_busy_q, rx_busy_d;

  logic          change_s, valid_s, prev_valid_s, bit_val_s, bit_bad_s;

  // Next-state logic for line tracking, FSM and word assembly
  always_comb begin
    change_s     = (sync2_q != prev_q);
    valid_s      = (sync2_q == LVL_HI) || (sync2_q == LVL_LO);
    prev_valid_s = (prev_q == LVL_HI) || (prev_q == LVL_LO);
    bit_val_s    = (samp_a_q == LVL_HI) && (sync2_q == LVL_LO);
    bit_bad_s    = !(bit_val_s || ((samp_a_q == LVL_LO) && (sync2_q == LVL_HI)));

    if (change_s) begin
      run_d = 8'd1;
    end else if (run_q == 8'd255) begin
      run_d = run_q;
    end else begin
      run_d = run_q + 8'd1;
    end

    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    samp_a_d  = samp_a_q;
    shreg_d   = shreg_q;
    man_err_d = man_err_q;
    cd_next_d = cd_next_q;
    rx_done_d = 1'b0;
    rx_data_d = rx_data_q;
    rx_cd_d   = rx_cd_q;
    p_error_d = p_error_q;

    case (state_q)
      IDLE: begin
        // A HI<->LO edge after a long enough first half marks the mid-sync point
        if (change_s && valid_s && prev_valid_s && (run_q >= SYNC_MIN_C)) begin
          state_d   = SYNC2;
          cnt_d     = 8'd1;
          cd_next_d = (prev_q == LVL_LO);
          man_err_d = 1'b0;
          shreg_d   = 16'h0000;
        end else begin
          state_d = IDLE;
        end
      end
      SYNC2: begin
        cnt_d = cnt_q + 8'd1;
        if ((change_s || !valid_s) && (cnt_q < SYNC_MIN_C)) begin
          state_d = IDLE;
        end else if (cnt_q == SYNC_LAST) begin
          state_d = DATA;
          phase_d = '0;
          bit_d   = 5'd0;
        end else begin
          state_d = SYNC2;
        end
      end
      DATA: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          bit_d   = bit_q + 5'd1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
        if (phase_q == PH_A) begin
          samp_a_d = sync2_q;
        end else if (phase_q == PH_B) begin
          man_err_d = man_err_q | bit_bad_s;
          if (bit_q == 5'd16) begin
            state_d   = IDLE;
            rx_done_d = 1'b1;
            rx_data_d = shreg_q;
            rx_cd_d   = cd_next_q;
            p_error_d = man_err_q | bit_bad_s | ~((^shreg_q) ^ bit_val_s);
          end else begin
            shreg_d = {shreg_q[14:0], bit_val_s};
          end
        end else begin
          samp_a_d = samp_a_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rx_busy_d = (state_d == SYNC2) || (state_d == DATA);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      prev_q    <= 2'b00;
      run_q     <= 8'd0;
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      phase_q   <= '0;
      bit_q     <= 5'd0;
      samp_a_q  <= 2'b00;
      shreg_q   <= 16'h0000;
      man_err_q <= 1'b0;
      cd_next_q <= 1'b0;
      rx_done_q <= 1'b0;
      rx_data_q <= 16'h0000;
      rx_cd_q   <= 1'b0;
      p_error_q <= 1'b0;
      rx_busy_q <= 1'b0;
    end else begin
      sync1_q   <= {bus.rx_p, bus.rx_n};
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      run_q     <= run_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      samp_a_q  <= samp_a_d;
      shreg_q   <= shreg_d;
      man_err_q <= man_err_d;
      cd_next_q <= cd_next_d;
      rx_done_q <= rx_done_d;
      rx_data_q <= rx_data_d;
      rx_cd_q   <= rx_cd_d;
      p_error_q <= p_error_d;
      rx_busy_q <= rx_busy_d;
    end
  end

  assign bus.rx_done = rx_done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.rx_cd   = rx_cd_q;
  assign bus.p_error = p_error_q;
  assign bus.rx_busy = rx_busy_q;
endmodule

// File: tb/tb_mkio_word_receiver.sv
// Directed bench for mkio_word_receiver: Manchester frames driven at 16 clk/bit,
// decoded words and rx_done timing compared against hand-computed values.
module tb_mkio_word_receiver;
  localparam logic [1:0] HI  = 2'b10;
  localparam logic [1:0] LO  = 2'b01;
  localparam logic [1:0] INV = 2'b00;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mkio_word_receiver_if bus();

  mkio_word_receiver #(.CLKS_PER_BIT(16), .SYNC_MIN(20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;
  int done_cnt = 0;
  int dbl_cnt = 0;
  int t_mid = 0;
  logic prev_done = 1'b0;
  logic busy_mid;
  logic [19:0] rst_snap;
  logic [15:0] cap_data [16];
  logic        cap_cd   [16];
  logic        cap_perr [16];
  int          cap_cyc  [16];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every rx_done pulse and flag any pulse longer than one cycle
  always @(negedge clk) begin
    if (bus.rx_done === 1'b1) begin
      if (done_cnt < 16) begin
        cap_data[done_cnt] = bus.rx_data;
        cap_cd[done_cnt]   = bus.rx_cd;
        cap_perr[done_cnt] = bus.p_error;
        cap_cyc[done_cnt]  = cyc;
      end
      done_cnt = done_cnt + 1;
      if (prev_done) dbl_cnt = dbl_cnt + 1;
    end
    prev_done = (bus.rx_done === 1'b1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    if (obs !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [1:0] lvl, input int n);
    {bus.rx_p, bus.rx_n} = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 20-bit-time frame; bad_k forces bit k HI for both halves, rst_k pulses reset during bit k
  task automatic send_word(input logic cd, input logic [15:0] data, input logic pbit,
                           input int bad_k, input int rst_k);
    logic b;
    hold(cd ? LO : HI, 24);
    t_mid = cyc;
    hold(cd ? HI : LO, 24);
    for (int k = 0; k < 17; k++) begin
      b = (k < 16) ? data[15 - k] : pbit;
      if (k == 8) busy_mid = bus.rx_busy;
      if (k == rst_k) reset = 1'b1;
      if (k == bad_k) hold(HI, 8);
      else hold(b ? HI : LO, 8);
      if (k == rst_k) begin
        rst_snap = {bus.rx_done, bus.rx_data, bus.rx_cd, bus.p_error, bus.rx_busy};
        reset = 1'b0;
      end
      if (k == bad_k) hold(HI, 8);
      else hold(b ? LO : HI, 8);
    end
  endtask

  int d0;

  initial begin
    reset = 1'b1;
    {bus.rx_p, bus.rx_n} = INV;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {12'h0, bus.rx_done, bus.rx_data, bus.rx_cd, bus.p_error, bus.rx_busy}, 32'h0);
    reset = 1'b0;
    hold(INV, 10);

    // 1: command sync, 0x0843, correct parity; rx_done 293 cycles after t0 plus 2 synchronizer cycles
    d0 = done_cnt;
    send_word(1'b0, 16'h0843, 1'b1, -1, -1);
    hold(INV, 20);
    check_eq("t1_done_cnt", done_cnt - d0, 1);
    check_eq("t1_latency", cap_cyc[d0] - t_mid, 295);
    check_eq("t1_data", cap_data[d0], 16'h0843);
    check_eq("t1_cd", cap_cd[d0], 1'b0);
    check_eq("t1_perr", cap_perr[d0], 1'b0);
    check_eq("t1_busy_mid", busy_mid, 1'b1);
    check_eq("t1_busy_after", bus.rx_busy, 1'b0);
    check_eq("t1_data_held", bus.rx_data, 16'h0843);

    // 2: data sync, 0xA5A5
    d0 = done_cnt;
    send_word(1'b1, 16'hA5A5, 1'b1, -1, -1);
    hold(INV, 20);
    check_eq("t2_done_cnt", done_cnt - d0, 1);
    check_eq("t2_data", cap_data[d0], 16'hA5A5);
    check_eq("t2_cd", cap_cd[d0], 1'b1);
    check_eq("t2_perr", cap_perr[d0], 1'b0);

    // 3: parity bit wrong
    d0 = done_cnt;
    send_word(1'b0, 16'h0843, 1'b0, -1, -1);
    hold(INV, 20);
    check_eq("t3_done_cnt", done_cnt - d0, 1);
    check_eq("t3_data", cap_data[d0], 16'h0843);
    check_eq("t3_perr", cap_perr[d0], 1'b1);

    // 4: Manchester violation on bit 5 (rx_data[10])
    d0 = done_cnt;
    send_word(1'b1, 16'hFFFF, 1'b1, 5, -1);
    hold(INV, 20);
    check_eq("t4_done_cnt", done_cnt - d0, 1);
    check_eq("t4_data", cap_data[d0], 16'hFBFF);
    check_eq("t4_cd", cap_cd[d0], 1'b1);
    check_eq("t4_perr", cap_perr[d0], 1'b1);

    // 5: short first half, then second half broken at cycle 12, then a valid word
    d0 = done_cnt;
    hold(HI, 10);
    hold(LO, 24);
    hold(INV, 40);
    check_eq("t5_short_first", done_cnt - d0, 0);
    hold(HI, 24);
    hold(LO, 8);
    check_eq("t5_busy_in_sync2", bus.rx_busy, 1'b1);
    hold(LO, 4);
    hold(HI, 30);
    hold(INV, 40);
    check_eq("t5_broken_second", done_cnt - d0, 0);
    check_eq("t5_busy_idle", bus.rx_busy, 1'b0);
    send_word(1'b0, 16'h5A3C, 1'b1, -1, -1);
    hold(INV, 20);
    check_eq("t5_recover_cnt", done_cnt - d0, 1);
    check_eq("t5_recover_data", cap_data[d0], 16'h5A3C);
    check_eq("t5_recover_perr", cap_perr[d0], 1'b0);

    // 6: back-to-back words, then reset during a third word
    d0 = done_cnt;
    send_word(1'b0, 16'h0843, 1'b1, -1, -1);
    send_word(1'b1, 16'h1234, 1'b0, -1, -1);
    send_word(1'b0, 16'h0843, 1'b1, -1, 6);
    hold(INV, 40);
    check_eq("t6_done_cnt", done_cnt - d0, 2);
    check_eq("t6_spacing", cap_cyc[d0 + 1] - cap_cyc[d0], 320);
    check_eq("t6_w1_data", cap_data[d0], 16'h0843);
    check_eq("t6_w1_cd", cap_cd[d0], 1'b0);
    check_eq("t6_w2_data", cap_data[d0 + 1], 16'h1234);
    check_eq("t6_w2_cd", cap_cd[d0 + 1], 1'b1);
    check_eq("t6_w2_perr", cap_perr[d0 + 1], 1'b0);
    check_eq("t6_in_reset", {12'h0, rst_snap}, 32'h0);
    check_eq("t6_after_reset", {12'h0, bus.rx_done, bus.rx_data, bus.rx_cd, bus.p_error, bus.rx_busy}, 32'h0);

    check_eq("done_one_cycle", dbl_cnt, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
